// File: rtl/ehgu_blk_rev_pkg.sv
// Shared types and constants for the block-reversal buffer.
package ehgu_blk_rev_pkg;

    // Reader sequencer states.
    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_RUN  = 1'b1
    } rd_state_t;

    // Number of entries in the output skid buffer.
    localparam int SKID_DEPTH = 2;

    // Flat memory address of element idx in bank sel (banks are blk entries apart).
    function automatic int bank_addr(input logic sel, input int blk, input int idx);
        return sel ? (blk + idx) : idx;
    endfunction

endpackage

// File: rtl/ehgu_ram_dual_port.sv
// Simple dual-port RAM: one write port, one read port with a registered read.
module ehgu_ram_dual_port #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wenable,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             renable,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_reg;

    // Write port.
    always_ff @(posedge clk) begin
        if (wenable) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: data appears the cycle after renable.
    always_ff @(posedge clk) begin
        if (renable) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/ehgu_blk_rev_mem.sv
// Ping-pong block reverser: fills one bank while the other is read back
// from its highest index down to zero through a 2-entry skid buffer.
module ehgu_blk_rev_mem
    import ehgu_blk_rev_pkg::*;
#(
    parameter int BLOCK = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    localparam int DEPTH = 2 * BLOCK;
    localparam int AW    = $clog2(DEPTH);
    localparam int IW    = $clog2(BLOCK);
    localparam logic [IW-1:0] IDX_LAST = IW'(BLOCK - 1);

    logic [1:0]       full_reg, full_next, full_set, full_clr;
    logic             wsel_reg, wsel_next;
    logic [IW-1:0]    widx_reg, widx_next;
    logic             rsel_reg, rsel_next;
    logic [IW-1:0]    ridx_reg, ridx_next, ridx_cur;
    rd_state_t        state_reg, state_next;

    logic             accept, issue, pop, rd_active;
    logic [2:0]       occ;
    logic [AW-1:0]    waddr, raddr;
    logic [WIDTH-1:0] rdata;

    logic             pend_reg, pend_last_reg;
    logic [1:0]       count_reg, count_next;
    logic [WIDTH-1:0] buf_data_reg  [SKID_DEPTH];
    logic [WIDTH-1:0] buf_data_next [SKID_DEPTH];
    logic             buf_last_reg  [SKID_DEPTH];
    logic             buf_last_next [SKID_DEPTH];

    assign in_ready  = ~full_reg[wsel_reg];
    assign accept    = in_valid & in_ready;
    // The head is either a buffered entry or the RAM output of last cycle's read.
    assign out_valid = (count_reg != 2'd0) | pend_reg;
    assign pop       = out_valid & out_ready;
    // Occupancy the buffer will reach if nothing new is issued this cycle.
    assign occ       = 3'(count_reg) + 3'(pend_reg) - 3'(pop);
    // A full read bank lets the reader issue straight from idle; ridx is
    // always BLOCK-1 while idle, so that is the index used.
    assign rd_active = (state_reg == RD_RUN) | full_reg[rsel_reg];
    assign ridx_cur  = (state_reg == RD_IDLE) ? IDX_LAST : ridx_reg;
    assign issue     = rd_active & (occ < 3'(SKID_DEPTH));

    assign waddr = AW'(bank_addr(wsel_reg, BLOCK, int'(widx_reg)));
    assign raddr = AW'(bank_addr(rsel_reg, BLOCK, int'(ridx_cur)));

    assign out_data = (count_reg != 2'd0) ? buf_data_reg[0] : (pend_reg ? rdata : '0);
    assign out_last = (count_reg != 2'd0) ? buf_last_reg[0] : (pend_reg & pend_last_reg);

    ehgu_ram_dual_port #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wenable (accept),
        .waddr   (waddr),
        .wdata   (in_data),
        .renable (issue),
        .raddr   (raddr),
        .rdata   (rdata)
    );

    // Writer: advance the fill index and hand a completed bank to the reader.
    always_comb begin
        wsel_next = wsel_reg;
        widx_next = widx_reg;
        full_set  = '0;
        if (accept) begin
            if (widx_reg == IDX_LAST) begin
                full_set[wsel_reg] = 1'b1;
                wsel_next          = ~wsel_reg;
                widx_next          = '0;
            end else begin
                widx_next = widx_reg + IW'(1);
            end
        end
    end

    // Reader FSM: walk the full bank downwards, release it on the index-0 read.
    always_comb begin
        state_next = state_reg;
        rsel_next  = rsel_reg;
        ridx_next  = ridx_reg;
        full_clr   = '0;
        if ((state_reg == RD_IDLE) && full_reg[rsel_reg]) begin
            state_next = RD_RUN;
            ridx_next  = IDX_LAST;
        end
        if (issue) begin
            if (ridx_cur == '0) begin
                full_clr[rsel_reg] = 1'b1;
                rsel_next          = ~rsel_reg;
                ridx_next          = IDX_LAST;
                state_next         = full_reg[~rsel_reg] ? RD_RUN : RD_IDLE;
            end else begin
                ridx_next  = ridx_cur - IW'(1);
                state_next = RD_RUN;
            end
        end
    end

    // Writer and reader always touch different banks, so set and clear compose.
    assign full_next = (full_reg | full_set) & ~full_clr;

    // Skid buffer: pop the head, then append the returning RAM word unless it
    // was consumed directly as the head this cycle.
    always_comb begin
        buf_data_next = buf_data_reg;
        buf_last_next = buf_last_reg;
        count_next    = occ[1:0];
        if (count_reg == 2'd0) begin
            if (pend_reg && !pop) begin
                buf_data_next[0] = rdata;
                buf_last_next[0] = pend_last_reg;
            end
        end else begin
            if (pop) begin
                buf_data_next[0] = buf_data_reg[1];
                buf_last_next[0] = buf_last_reg[1];
            end
            if (pend_reg) begin
                if ((count_reg == 2'd1) && pop) begin
                    buf_data_next[0] = rdata;
                    buf_last_next[0] = pend_last_reg;
                end else begin
                    buf_data_next[1] = rdata;
                    buf_last_next[1] = pend_last_reg;
                end
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full_reg      <= '0;
            wsel_reg      <= 1'b0;
            widx_reg      <= '0;
            rsel_reg      <= 1'b0;
            ridx_reg      <= IDX_LAST;
            state_reg     <= RD_IDLE;
            pend_reg      <= 1'b0;
            pend_last_reg <= 1'b0;
            count_reg     <= 2'd0;
        end else begin
            full_reg      <= full_next;
            wsel_reg      <= wsel_next;
            widx_reg      <= widx_next;
            rsel_reg      <= rsel_next;
            ridx_reg      <= ridx_next;
            state_reg     <= state_next;
            pend_reg      <= issue;
            pend_last_reg <= issue & (ridx_cur == '0);
            count_reg     <= count_next;
        end
    end

    // Skid buffer entries, one register slice per entry.
    generate
        for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_skid
            // Entry storage.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    buf_data_reg[gi] <= '0;
                    buf_last_reg[gi] <= 1'b0;
                end else begin
                    buf_data_reg[gi] <= buf_data_next[gi];
                    buf_last_reg[gi] <= buf_last_next[gi];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ehgu_blk_rev_mem.sv
// Directed bench for ehgu_blk_rev_mem with BLOCK = 4, WIDTH = 8.
module tb_ehgu_blk_rev_mem;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;

    int tests_run = 0;
    int tests_failed = 0;

    int in_q[$];
    int exp_q[$];
    bit explast_q[$];
    int acc_cyc[$];
    int first_out_cyc;
    int last_out_cyc;
    int ready_low_cnt;

    always #5 clk = ~clk;

    ehgu_blk_rev_mem #(
        .BLOCK (4),
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        #1;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_last", out_last, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // mode 0: out_ready high; 1: low for 20 cycles then high; 2: toggling 1,0,...
    task automatic run_stream(input int mode, input int budget);
        int in_idx = 0;
        int out_idx = 0;
        bit done = 0;
        bit held_v = 0;
        logic [7:0] held_d = 8'h00;
        logic held_l = 1'b0;
        first_out_cyc = -1;
        last_out_cyc  = -1;
        ready_low_cnt = 0;
        acc_cyc.delete();
        for (int cyc = 0; cyc < budget && !done; cyc++) begin
            @(negedge clk);
            case (mode)
                1:       out_ready = (cyc >= 20);
                2:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'b1;
            endcase
            in_valid = (in_idx < in_q.size());
            in_data  = in_valid ? 8'(in_q[in_idx]) : 8'h00;
            #1;
            if (held_v) begin
                check_val("hold_valid", out_valid, 1);
                check_val("hold_data", out_data, held_d);
                check_val("hold_last", out_last, held_l);
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
            held_l = out_last;
            if (in_valid && !in_ready) ready_low_cnt++;
            if (out_valid && out_ready) begin
                $display("[TB] cyc %0d out data %0d last %0d", cyc, out_data, out_last);
                if (out_idx < exp_q.size()) begin
                    check_val("out_data", out_data, exp_q[out_idx]);
                    check_val("out_last", out_last, explast_q[out_idx]);
                end else begin
                    check_val("extra_out", out_idx, exp_q.size());
                end
                if (first_out_cyc < 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
                out_idx++;
            end
            if (in_valid && in_ready) begin
                $display("[TB] cyc %0d in data %0d", cyc, in_data);
                acc_cyc.push_back(cyc);
                in_idx++;
            end
            if (in_idx == in_q.size() && out_idx == exp_q.size()) done = 1;
        end
        check_val("in_count", in_idx, in_q.size());
        check_val("out_count", out_idx, exp_q.size());
        // Idle tail: nothing more may come out.
        repeat (6) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1;
            check_val("no_stray_out", out_valid, 0);
        end
    endtask

    initial begin
        // Single block, first-output latency.
        do_reset();
        in_q      = '{1, 2, 3, 4};
        exp_q     = '{4, 3, 2, 1};
        explast_q = '{0, 0, 0, 1};
        run_stream(0, 100);
        check_val("t1_latency", first_out_cyc - acc_cyc[3], 2);

        // Three blocks streamed back to back.
        do_reset();
        in_q      = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
        exp_q     = '{4, 3, 2, 1, 8, 7, 6, 5, 12, 11, 10, 9};
        explast_q = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
        run_stream(0, 100);
        check_val("t2_in_ready_low", ready_low_cnt, 0);
        check_val("t2_no_gap", last_out_cyc - first_out_cyc, 11);
        check_val("t2_first_out", first_out_cyc, 5);

        // Both banks fill while the output is stalled.
        do_reset();
        in_q      = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        exp_q     = '{4, 3, 2, 1, 8, 7, 6, 5};
        explast_q = '{0, 0, 0, 1, 0, 0, 0, 1};
        run_stream(1, 100);
        check_val("t3_ready_low_cycles", ready_low_cnt, 14);
        check_val("t3_acc9_cycle", acc_cyc[8], 22);
        check_val("t3_first_out", first_out_cyc, 20);

        // Toggling out_ready over three blocks.
        do_reset();
        in_q      = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
        exp_q     = '{4, 3, 2, 1, 8, 7, 6, 5, 12, 11, 10, 9};
        explast_q = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
        run_stream(2, 200);

        // Partial block discarded by a reset in mid-operation.
        do_reset();
        in_q = '{1, 2};
        exp_q.delete();
        explast_q.delete();
        run_stream(0, 20);
        do_reset();
        in_q      = '{5, 6, 7, 8};
        exp_q     = '{8, 7, 6, 5};
        explast_q = '{0, 0, 0, 1};
        run_stream(0, 100);
        check_val("t5_latency", first_out_cyc - acc_cyc[3], 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
